// File: rtl/window3x3_8bit.sv
// 3x3 sliding-window generator for an 8-bit raster pixel stream.
// Two line buffers and a 3x3 shift register feed each complete window to a 9-input sorter.
module window3x3_8bit #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    input  logic       sof,
    output logic [7:0] win [8:0],
    output logic       win_valid,
    output logic       eof
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0] col_q, col_d, colCur;
    logic [RW-1:0] row_q, row_d, rowCur;
    logic [7:0]    win_q [8:0];
    logic [7:0]    win_d [8:0];
    logic          winValid_q, winValid_d;
    logic          eof_q, eof_d;
    logic [7:0]    lineBuf1 [IMG_W];
    logic [7:0]    lineBuf2 [IMG_W];
    logic [7:0]    above1, above2;

    // sof pins the current pixel to the frame origin whatever the counters hold
    always_comb begin
        colCur     = sof ? '0 : col_q;
        rowCur     = sof ? '0 : row_q;
        above1     = lineBuf1[colCur];
        above2     = lineBuf2[colCur];
        col_d      = col_q;
        row_d      = row_q;
        win_d      = win_q;
        winValid_d = 1'b0;
        eof_d      = 1'b0;
        if (pix_valid) begin
            if (colCur == COL_LAST) begin
                col_d = '0;
                row_d = (rowCur == ROW_LAST) ? '0 : rowCur + 1'b1;
            end else begin
                col_d = colCur + 1'b1;
                row_d = rowCur;
            end
            win_d[8] = win_q[7];
            win_d[7] = win_q[6];
            win_d[6] = above2;
            win_d[5] = win_q[4];
            win_d[4] = win_q[3];
            win_d[3] = above1;
            win_d[2] = win_q[1];
            win_d[1] = win_q[0];
            win_d[0] = pix_in;
            // rows 0 and 1 refill both buffers, so stale contents never reach a flagged window
            winValid_d = (rowCur >= ROW_TWO) && (colCur >= COL_TWO);
            eof_d      = (rowCur == ROW_LAST) && (colCur == COL_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q      <= '0;
            row_q      <= '0;
            winValid_q <= 1'b0;
            eof_q      <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            winValid_q <= winValid_d;
            eof_q      <= eof_d;
            win_q      <= win_d;
        end
    end

    // Line buffers are deliberately left out of reset; reads see pre-write data
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lineBuf2[colCur] <= above1;
            lineBuf1[colCur] <= pix_in;
        end
    end

    assign win       = win_q;
    assign win_valid = winValid_q;
    assign eof       = eof_q;

endmodule

// File: doc/window3x3_8bit.md
WINDOW3X3_8BIT -- requirements
Module: window3x3_8bit

Interface
REQ-001 SHALL have parameter IMG_W, default 640, meaning active pixels per line (legal 3..4096).
REQ-002 SHALL have parameter IMG_H, default 480, meaning lines per frame (legal 3..4096).
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port pix_in  input  8  raster-order pixel sample.
REQ-006 SHALL have port pix_valid  input  1  pix_in is accepted on this clk edge.
REQ-007 SHALL have port sof  input  1  start of frame; qualified by pix_valid; marks pix_in as row 0, col 0.
REQ-008 SHALL have port win  output  8 x [8:0] unpacked  3x3 window, directly feeding the 9-input 8-bit sorter's entrada[8:0].
REQ-009 SHALL have port win_valid  output  1  win holds a complete new window this cycle.
REQ-010 SHALL have port eof  output  1  one-cycle pulse: last pixel of frame accepted.

Function
REQ-011 SHALL keep col (0..IMG_W-1) and row (0..IMG_H-1) counters, advancing only on accepted pixels (pix_valid=1).
REQ-012 SHALL wrap col IMG_W-1 -> 0 with row+1; SHALL wrap row IMG_H-1 -> 0 at col wrap (frame end).
REQ-013 SHALL, on pix_valid=1 with sof=1, treat pix_in as row 0/col 0 regardless of counter state; next pixel is col 1.
REQ-014 SHALL hold two line buffers of IMG_W x 8 bits storing rows r-1 and r-2, indexed by col; read and write of same col in same cycle SHALL return old data.
REQ-015 SHALL keep a 3x3 shift register: each accepted pixel shifts columns left, new column = {row r-2, row r-1, pix_in} at current col.
REQ-016 SHALL map win[8..6] = row r-2 cols c-2..c, win[5..3] = row r-1 cols c-2..c, win[2..0] = row r cols c-2..c; win[0] = newest pixel.
REQ-017 SHALL assert win_valid for exactly one cycle, one clk after an accepted pixel with row>=2 and col>=2; win updates on that same edge.
REQ-018 SHALL produce (IMG_W-2)*(IMG_H-2) valid windows per frame; no border padding, no windows spanning line wrap.
REQ-019 SHALL assert eof one clk after accepting pixel (IMG_H-1, IMG_W-1), coincident with that window's win_valid.
REQ-020 SHALL hold win, counters and buffers unchanged and drive win_valid=0, eof=0 in cycles with pix_valid=0.
REQ-021 SHALL accept one pixel per clk with no backpressure; sustained pix_valid=1 SHALL yield one window per clk in the valid region.
REQ-022 SHALL, on sof arriving mid-frame, discard partial frame; line buffer stale data never reaches a valid window (gated by row>=2).

Reset
REQ-023 SHALL, while reset=1, force col=0, row=0, all win elements=0, win_valid=0, eof=0, asynchronously.
REQ-024 SHALL NOT clear line buffer contents on reset; outputs SHALL remain correct because of REQ-017 gating.
REQ-025 SHALL, after reset deasserts mid-frame, treat the next accepted pixel as row 0/col 0 even without sof.

Verification (IMG_W=4, IMG_H=4, pix = 4*row+col)
REQ-026 SHALL pass: reset, then 16 contiguous pixels with sof on first -> first win_valid one clk after pixel 10, win[8..0] = 0,1,2,4,5,6,8,9,10.
REQ-027 SHALL pass: same frame -> exactly 4 win_valid pulses, windows ending at pixels 10,11,14,15; eof high only with the window for 15.
REQ-028 SHALL pass: same frame with pix_valid low for 3 cycles between every pixel -> identical window sequence, win_valid never high during gaps.
REQ-029 SHALL pass: sof asserted at pixel index 6 of a frame, then new 16-pixel frame -> no win_valid until new pixel 10, window as in REQ-026.
REQ-030 SHALL pass: reset pulsed after pixel 12 -> win=0 and win_valid=0 immediately; next 16 pixels (no sof) yield REQ-026/027 results.
REQ-031 SHALL pass: two back-to-back frames feeding sorter -> 8 windows total, 2 eof pulses, zero idle clks between frames.
